// File: rtl/rd_req_arbiter_if.sv
// Bundle of every non-clock, non-reset signal of rd_req_arbiter.
//   slave  modport : the arbiter's view (requests and responses in, grants and
//                    routed traffic out).
//   master modport : the environment's view (SMEM lanes plus the IO block).
// Signals:
//   enable                 grant enable
//   req_valid / req_addr   per-requester request valid and 58-bit line address
//   req_ready              one-hot grant
//   spl_tx_rd_almostfull   IO read channel almost-full
//   cor_tx_rd_*            registered read request to IO
//   io_rx_*                read response from IO
//   rsp_valid / rsp_data   registered routed response
//   idle / tag_err         status
interface rd_req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 16
);
  logic                 enable;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*58-1:0]  req_addr;
  logic [N_REQ-1:0]     req_ready;
  logic                 spl_tx_rd_almostfull;
  logic                 cor_tx_rd_valid;
  logic [57:0]          cor_tx_rd_addr;
  logic [TAG_W-1:0]     cor_tx_rd_tag;
  logic                 io_rx_rd_valid;
  logic [511:0]         io_rx_data;
  logic [TAG_W-1:0]     io_rx_tag;
  logic [N_REQ-1:0]     rsp_valid;
  logic [511:0]         rsp_data;
  logic                 idle;
  logic                 tag_err;

  modport slave (
    input  enable, req_valid, req_addr, spl_tx_rd_almostfull,
    input  io_rx_rd_valid, io_rx_data, io_rx_tag,
    output req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_tag,
    output rsp_valid, rsp_data, idle, tag_err
  );

  modport master (
    output enable, req_valid, req_addr, spl_tx_rd_almostfull,
    output io_rx_rd_valid, io_rx_data, io_rx_tag,
    input  req_ready, cor_tx_rd_valid, cor_tx_rd_addr, cor_tx_rd_tag,
    input  rsp_valid, rsp_data, idle, tag_err
  );
endinterface

// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter sharing the single core-to-IO read request channel among
// N_REQ SMEM lanes. Each issued request carries the winning requester ID in the
// low tag bits; each response is routed back to the requester named in its
// tag. Per-requester and global outstanding limits are enforced, and new grants
// stop while the IO channel reports almost-full.
// Ports:
//   clk        clock
//   spl_reset  synchronous active-high reset
//   bus        rd_req_arbiter_if.slave (request, IO and response signals)
module rd_req_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TAG_W       = 16,
  parameter int MAX_PER_REQ = 8,
  parameter int MAX_TOTAL   = 32
) (
  input  logic          clk,
  input  logic          spl_reset,
  rd_req_arbiter_if.slave bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int CNT_W  = $clog2(MAX_PER_REQ + 1);
  localparam int TOT_W  = $clog2(MAX_TOTAL + 1);
  localparam int ADDR_W = 58;
  localparam int DATA_W = 512;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_REQ);
  localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_TOTAL);

  logic [CNT_W-1:0]  cnt [N_REQ];
  logic [TOT_W-1:0]  total;
  logic [ID_W-1:0]   ptr;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  grant_oh;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  int                idx;
  logic [ID_W-1:0]   cand;

  logic [ID_W-1:0]   rsp_id;
  logic [ID_W-1:0]   rsp_sel;
  logic              rsp_in_range;
  logic              rsp_hi_zero;
  logic              rsp_ok;
  logic              rsp_bad;
  logic              any_out;

  logic              tx_vld_p1;
  logic [ADDR_W-1:0] tx_addr_p1;
  logic [TAG_W-1:0]  tx_tag_p1;
  logic [N_REQ-1:0]  rsp_vld_p1;
  logic [DATA_W-1:0] rsp_data_p1;
  logic              tag_err_q;

  // Eligibility uses registered counts only, so a response arriving in the
  // same cycle cannot unblock a requester sitting at its limit.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req_valid[i] && bus.enable && !bus.spl_tx_rd_almostfull &&
                (cnt[i] < CNT_MAX) && (total < TOT_MAX);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!grant_vld && elig[cand]) begin
        grant_vld      = 1'b1;
        grant_id       = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

  // Response decode; rsp_sel keeps the counter lookup in range when the ID
  // field names a requester that does not exist.
  always_comb begin
    rsp_id       = bus.io_rx_tag[ID_W-1:0];
    rsp_in_range = (int'(rsp_id) < N_REQ);
    rsp_hi_zero  = (bus.io_rx_tag[TAG_W-1:ID_W] == '0);
    rsp_sel      = rsp_in_range ? rsp_id : '0;
    rsp_ok       = bus.io_rx_rd_valid && rsp_in_range && rsp_hi_zero &&
                   (cnt[rsp_sel] != '0);
    rsp_bad      = bus.io_rx_rd_valid && !rsp_ok;
  end

  always_comb begin
    any_out = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      any_out = any_out | (cnt[i] != '0);
    end
  end

  // Outstanding counters and round-robin pointer
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      total <= '0;
      ptr   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant_vld && grant_id == ID_W'(i) && !(rsp_ok && rsp_sel == ID_W'(i)))
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (rsp_ok && rsp_sel == ID_W'(i) && !(grant_vld && grant_id == ID_W'(i)))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (grant_vld && !rsp_ok)
        total <= total + TOT_W'(1);
      else if (rsp_ok && !grant_vld)
        total <= total - TOT_W'(1);
      if (grant_vld)
        ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Stage p1: registered request and routed response
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      tx_vld_p1   <= 1'b0;
      tx_addr_p1  <= '0;
      tx_tag_p1   <= '0;
      rsp_vld_p1  <= '0;
      rsp_data_p1 <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      tx_vld_p1 <= grant_vld;
      if (grant_vld) begin
        tx_addr_p1 <= bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        tx_tag_p1  <= TAG_W'(grant_id);
      end
      rsp_vld_p1 <= rsp_ok ? (N_REQ'(1) << rsp_sel) : '0;
      if (rsp_ok) rsp_data_p1 <= bus.io_rx_data;
      if (rsp_bad) tag_err_q <= 1'b1;
    end
  end

  assign bus.req_ready       = grant_oh;
  assign bus.cor_tx_rd_valid = tx_vld_p1;
  assign bus.cor_tx_rd_addr  = tx_addr_p1;
  assign bus.cor_tx_rd_tag   = tx_tag_p1;
  assign bus.rsp_valid       = rsp_vld_p1;
  assign bus.rsp_data        = rsp_data_p1;
  assign bus.idle            = !any_out && !tx_vld_p1;
  assign bus.tag_err         = tag_err_q;
endmodule

// File: tb/tb_rd_req_arbiter.sv
module tb_rd_req_arbiter;
  localparam int N = 4;
  localparam int TW = 16;
  localparam int MAXR = 8;
  localparam int MAXT = 32;

  logic clk = 1'b0;
  logic spl_reset;
  always #5 clk = ~clk;

  rd_req_arbiter_if #(.N_REQ(N), .TAG_W(TW)) bus ();
  rd_req_arbiter #(.N_REQ(N), .TAG_W(TW), .MAX_PER_REQ(MAXR), .MAX_TOTAL(MAXT))
    dut (.clk(clk), .spl_reset(spl_reset), .bus(bus.slave));

  int n_total = 0;
  int n_bad = 0;

  // Reference model: outstanding reads per requester and overall, pointer,
  // and the output values the design must present after the next edge.
  int           mcnt [N];
  int           mtot;
  int           mptr;
  bit           exp_txv;
  logic [57:0]  exp_addr;
  int           exp_tag;
  logic [N-1:0] exp_rspv;
  logic [511:0] exp_rdata;
  bit           merr;
  logic [N-1:0] seen_ready;
  int           issues;
  logic [511:0] dword;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int i;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (bus.req_valid[i] && bus.enable && !bus.spl_tx_rd_almostfull &&
          mcnt[i] < MAXR && mtot < MAXT) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock cycle: check the grant against the model, advance the model,
  // then check the registered outputs just after the edge.
  task automatic tick();
    int g, id, busy;
    bit good, rst_now;
    #1;
    rst_now = spl_reset;
    seen_ready = bus.req_ready;
    g = model_grant();
    if (!rst_now) chk("ready", bus.req_ready, onehot(g));
    id = int'(bus.io_rx_tag[1:0]);
    good = bus.io_rx_rd_valid && (bus.io_rx_tag[TW-1:2] == '0) && mcnt[id] > 0;
    if (rst_now) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mtot = 0; mptr = 0; exp_txv = 0; exp_rspv = '0; merr = 0;
    end else begin
      exp_txv = (g >= 0);
      if (g >= 0) begin
        exp_addr = bus.req_addr[g*58 +: 58];
        exp_tag = g;
        mcnt[g]++; mtot++;
        mptr = (g + 1) % N;
      end
      exp_rspv = '0;
      if (good) begin
        exp_rspv[id] = 1'b1;
        exp_rdata = bus.io_rx_data;
        mcnt[id]--; mtot--;
      end else if (bus.io_rx_rd_valid) merr = 1;
    end
    @(posedge clk);
    #1;
    busy = mtot;
    chk("tx_valid", bus.cor_tx_rd_valid, exp_txv);
    if (exp_txv) begin
      chk("tx_addr", bus.cor_tx_rd_addr, exp_addr);
      chk("tx_tag", bus.cor_tx_rd_tag, exp_tag);
    end
    chk("rsp_valid", bus.rsp_valid, exp_rspv);
    if (exp_rspv != '0) chk("rsp_data", bus.rsp_data, exp_rdata);
    chk("idle", bus.idle, (busy == 0 && !exp_txv));
    chk("tag_err", bus.tag_err, merr);
    if (rst_now) begin
      chk("rst_addr", bus.cor_tx_rd_addr, 0);
      chk("rst_tag", bus.cor_tx_rd_tag, 0);
      chk("rst_data", bus.rsp_data, 0);
    end
  endtask

  task automatic quiet();
    bus.req_valid = '0;
    bus.io_rx_rd_valid = 1'b0;
    bus.io_rx_tag = '0;
    bus.spl_tx_rd_almostfull = 1'b0;
    bus.enable = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    spl_reset = 1'b1;
    tick();
    spl_reset = 1'b0;
  endtask

  task automatic respond(input int tag, input logic [511:0] d);
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_tag = TW'(tag);
    bus.io_rx_data = d;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mtot = 0; mptr = 0; exp_txv = 0; exp_addr = '0; exp_tag = 0;
    exp_rspv = '0; exp_rdata = '0; merr = 0;
    bus.req_addr = '0;
    bus.io_rx_data = '0;
    quiet();
    spl_reset = 1'b1;
    tick();
    spl_reset = 1'b0;
    chk("reset_idle", bus.idle, 1'b1);
    chk("reset_txv", bus.cor_tx_rd_valid, 1'b0);

    // Single requester 2
    for (int i = 0; i < N; i++) bus.req_addr[i*58 +: 58] = 58'(32'h10 * (i + 1));
    bus.req_addr[2*58 +: 58] = 58'h100;
    bus.req_valid = 4'b0100;
    tick();
    chk("t1_ready", seen_ready, 4'b0100);
    chk("t1_addr", bus.cor_tx_rd_addr, 58'h100);
    chk("t1_tag", bus.cor_tx_rd_tag, 16'd2);
    chk("t1_idle", bus.idle, 1'b0);
    bus.req_valid = '0;
    tick();

    // All requesters: rotating order
    do_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t2_order", seen_ready, onehot(c % 4));
    end
    bus.req_valid = '0;
    tick();

    // Almost-full blocks grants
    do_reset();
    bus.req_valid = 4'b1111;
    bus.spl_tx_rd_almostfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_af_ready", seen_ready, 4'b0000);
      chk("t3_af_txv", bus.cor_tx_rd_valid, 1'b0);
    end
    bus.spl_tx_rd_almostfull = 1'b0;
    tick();
    chk("t3_resume", seen_ready, 4'b0001);
    chk("t3_resume_txv", bus.cor_tx_rd_valid, 1'b1);

    // Per-requester limit
    do_reset();
    bus.req_valid = 4'b0010;
    issues = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.cor_tx_rd_valid) issues++;
    end
    chk("t4_issues", issues, 8);
    chk("t4_blocked", seen_ready, 4'b0000);
    dword = rand512();
    respond(1, dword);
    tick();
    chk("t4_rspv", bus.rsp_valid, 4'b0010);
    chk("t4_rdata", bus.rsp_data, dword);
    bus.io_rx_rd_valid = 1'b0;
    tick();
    chk("t4_regrant", bus.cor_tx_rd_valid, 1'b1);
    tick();
    chk("t4_one_only", bus.cor_tx_rd_valid, 1'b0);

    // Simultaneous grant and response on requester 0, then drain and bad tag
    do_reset();
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) tick();
    respond(0, rand512());
    tick();
    bus.req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      respond(0, rand512());
      tick();
      chk("t5_not_idle", bus.idle, 1'b0);
    end
    respond(0, rand512());
    tick();
    chk("t5_idle", bus.idle, 1'b1);
    respond(5, rand512());
    tick();
    chk("t5_tag_err", bus.tag_err, 1'b1);
    chk("t5_no_rsp", bus.rsp_valid, 4'b0000);
    bus.io_rx_rd_valid = 1'b0;

    // Reset mid-operation
    do_reset();
    bus.req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) tick();
    quiet();
    spl_reset = 1'b1;
    tick();
    spl_reset = 1'b0;
    chk("t6_txv", bus.cor_tx_rd_valid, 1'b0);
    chk("t6_rspv", bus.rsp_valid, 4'b0000);
    chk("t6_idle", bus.idle, 1'b1);
    chk("t6_err0", bus.tag_err, 1'b0);
    respond(0, rand512());
    tick();
    chk("t6_late_err", bus.tag_err, 1'b1);
    chk("t6_late_rspv", bus.rsp_valid, 4'b0000);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int id;
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) bus.req_addr[i*58 +: 58] = {26'($urandom), $urandom};
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.spl_tx_rd_almostfull = ($urandom_range(0, 9) == 0);
      bus.io_rx_rd_valid = 1'b0;
      if ($urandom_range(0, 9) < 4) begin
        id = $urandom_range(0, N - 1);
        if (mcnt[id] > 0) respond(id, rand512());
      end
      spl_reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    spl_reset = 1'b0;
    quiet();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rd_req_arbiter.md
Name: rd_req_arbiter

Overview:
- Shares the single core-to-IO read request channel among N_REQ pipeline requesters (SMEM lanes) using round-robin arbitration.
- Tags each request with the requester ID, then routes each read response back to the requester named in its tag.
- Enforces per-requester and global outstanding-read limits, and respects IO almost-full backpressure.
- Sits between the SMEM lanes and the IO block's cor_tx_rd/io_rx_rd interface.

Parameters:
N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ), derived localparam
TAG_W, 16, width of request/response tag (mdata); ID occupies tag[ID_W-1:0], upper bits zero
MAX_PER_REQ, 8, maximum outstanding reads per requester
MAX_TOTAL, 32, maximum outstanding reads across all requesters

Ports:
clk  in  1  clock; all logic single-domain
spl_reset  in  1  reset, synchronous, active-high
enable  in  1  grant enable (driven by core_start); low blocks new grants only
req_valid  in  N_REQ  per-requester read request valid
req_addr  in  N_REQ*58  per-requester cache-line address; slice i = [58*i+57:58*i]
req_ready  out  N_REQ  combinational one-hot grant; handshake = req_valid[i] & req_ready[i]
spl_tx_rd_almostfull  in  1  IO read channel almost-full
cor_tx_rd_valid  out  1  registered read request valid
cor_tx_rd_addr  out  58  registered read address
cor_tx_rd_tag  out  TAG_W  registered tag {zeros, ID}
io_rx_rd_valid  in  1  read response valid
io_rx_data  in  512  read response data
io_rx_tag  in  TAG_W  read response tag
rsp_valid  out  N_REQ  registered one-hot response valid
rsp_data  out  512  registered response data, shared by all requesters
idle  out  1  high when all outstanding counters are zero and cor_tx_rd_valid is low
tag_err  out  1  sticky; set by a response whose ID >= N_REQ or whose target counter is zero

Behaviour:
- Reset values: all outputs 0; all outstanding counters 0; round-robin pointer 0; tag_err 0; idle 1 in the first cycle after reset.
- Eligibility: requester i is eligible when req_valid[i], enable, !spl_tx_rd_almostfull, cnt[i] < MAX_PER_REQ and total < MAX_TOTAL all hold.
- Arbitration: grant the first eligible requester scanning ptr, ptr+1, ... modulo N_REQ. At most one grant per cycle. req_ready is zero when nothing is eligible.
- On grant g, the registers load next cycle: cor_tx_rd_valid=1, cor_tx_rd_addr=req_addr slice g, cor_tx_rd_tag=g.
  - ptr <= (g+1) mod N_REQ.
  - cnt[g] and total increment.
  - Request latency is 1 cycle from handshake to cor_tx_rd_valid.
- With no grant, cor_tx_rd_valid=0 next cycle; it never holds high for 2 cycles on a single handshake.
- almostfull is sampled in the grant cycle only. A request already registered is always issued.
- Response path: on io_rx_rd_valid with id=io_rx_tag[ID_W-1:0] < N_REQ and cnt[id] > 0:
  - next cycle rsp_valid[id]=1 and rsp_data=io_rx_data;
  - cnt[id] and total decrement.
  - Latency is 1 cycle. There is no backpressure on responses; requesters must always accept.
- Bad response (id >= N_REQ, nonzero upper tag bits, or cnt[id]==0): rsp_valid stays 0, counters unchanged, tag_err <= 1 until reset.
- Simultaneous grant and response to the same requester in one cycle: cnt unchanged, total unchanged. Grant and response to different requesters: each counter moves independently, total unchanged.
- Counter limits: a counter at its limit blocks the grant that cycle; a response arriving in that same cycle does not enable it. The decision uses registered counts only.
- Responses may return out of order within a requester; ordering is the requester's responsibility.
- enable low: no new grants; in-flight responses still route and drain; idle rises when drained.
- Reset mid-operation: all state clears immediately the next cycle. Responses arriving after reset for pre-reset requests hit cnt==0 and set tag_err.

Test Plan:
- Only requester 2 valid, addr 0x100, enable=1 → req_ready=4'b0100 same cycle; next cycle cor_tx_rd_valid=1, addr 0x100, tag 2; cnt[2]=1; idle=0.
- All 4 valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; each cnt=2 with no responses.
- almostfull=1 for 5 cycles with requests pending → req_ready=0 and cor_tx_rd_valid=0 throughout; grants resume the cycle after almostfull drops.
- Requester 1 alone with no responses → exactly 8 issues, then req_ready[1]=0. One response with tag 1 → rsp_valid=4'b0010 next cycle with matching data, and one further grant follows.
- cnt[0]=3, grant to 0 and response tag 0 in the same cycle → cnt[0]=3 after; total unchanged. Response with tag 5 → tag_err=1, no rsp_valid.
- 3 outstanding, assert spl_reset for 1 cycle → all outputs 0, idle=1; late response tag 0 → tag_err=1.
